// File: rtl/phase_clock_gen.sv
// Multi-channel clock-phase generator: NUM_CH divided clocks with programmable
// half-period and phase, driven by a halt / free-run / single-step controller.
module phase_clock_gen #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 4,
  parameter int CNT_W = 16,
  localparam int NUM_CH = 2 ** CH_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              run_mode,
  input  logic              step_go,
  input  logic [CNT_W-1:0]  step_count,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_en,
  output logic [NUM_CH-1:0] fall_en,
  output logic              busy,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  tick_count
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [DIV_W-1:0]   div_q   [NUM_CH];
  logic [DIV_W-1:0]   phase_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_q   [NUM_CH];
  logic               tick;
  logic               cfg_ok;

  // A programmed half-period of 0 behaves exactly like 1.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

  function automatic logic [DIV_W-1:0] start_cnt(input logic [DIV_W-1:0] phase,
                                                 input logic [DIV_W-1:0] div);
    logic [DIV_W-1:0] last;
    last = eff_div(div) - DIV_W'(1);
    return (phase > last) ? last : phase;
  endfunction

  // NOTE: tick decodes the current registered state, so it describes the edge
  // about to happen, not the state that edge will write.
  assign tick   = (state == RUN) || ((state == STEP) && (remaining != '0));
  assign cfg_ok = cfg_we && (state == HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HALT;
      remaining  <= '0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      tick_count <= '0;
      clk_out    <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      // NOTE: the per-channel arrays are plain flops and reset must discard all
      // programming, so every entry is cleared here rather than left undefined.
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(1);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      rise_en <= '0;
      fall_en <= '0;
      cfg_err <= cfg_we && (state != HALT);

      case (state)
        HALT: begin
          if (run_mode) begin
            state <= RUN;
            busy  <= 1'b1;
          end else if (step_go && (step_count != '0)) begin
            state     <= STEP;
            remaining <= step_count;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (!run_mode) begin
            state <= HALT;
            busy  <= 1'b0;
          end
        end
        STEP: begin
          if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end
          if (remaining <= CNT_W'(1)) begin
            state <= HALT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= HALT;
          busy  <= 1'b0;
        end
      endcase

      // Realignment wins over both configuration and the tick of this cycle.
      if (sync_all) begin
        tick_count <= '0;
        clk_out    <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          cnt_q[i] <= start_cnt(phase_q[i], div_q[i]);
        end
      end else begin
        if (cfg_ok) begin
          div_q[cfg_ch]   <= cfg_div;
          phase_q[cfg_ch] <= cfg_phase;
          cnt_q[cfg_ch]   <= start_cnt(cfg_phase, cfg_div);
          clk_out[cfg_ch] <= 1'b0;
        end
        if (tick) begin
          tick_count <= tick_count + CNT_W'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_q[i] == eff_div(div_q[i]) - DIV_W'(1)) begin
              cnt_q[i]   <= '0;
              clk_out[i] <= ~clk_out[i];
              rise_en[i] <= ~clk_out[i];
              fall_en[i] <= clk_out[i];
            end else begin
              cnt_q[i] <= cnt_q[i] + DIV_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/phase_clock_gen.md
Name: phase_clock_gen

Overview:
Parametrised multi-channel clock-phase generator for the skeleton processor. It derives NUM_CH divided clock outputs (imem, dmem, processor and regfile domains) from the single master clock. Each channel has a programmable half-period and phase offset, plus per-channel rise and fall enable strobes. A halt/run/single-step controller lets benches and debug logic advance the whole system a fixed number of master ticks.

Parameters:
CH_W, 2, channel-select width; NUM_CH = 2**CH_W.
DIV_W, 4, width of half-period and phase fields.
CNT_W, 16, width of step counter and tick counter.

Ports:
clock  in  1  master clock, rising-edge.
reset  in  1  synchronous, active-high.
cfg_we  in  1  config write strobe.
cfg_ch  in  CH_W  channel written by cfg_we.
cfg_div  in  DIV_W  half-period in master ticks; 0 is treated as 1.
cfg_phase  in  DIV_W  initial counter offset.
run_mode  in  1  1 = free run, 0 = stop.
step_go  in  1  one-cycle pulse: start a step burst.
step_count  in  CNT_W  ticks to execute per burst.
sync_all  in  1  realign all channels.
clk_out  out  NUM_CH  divided clocks.
rise_en  out  NUM_CH  one-cycle pulse; clk_out bit just went 0->1.
fall_en  out  NUM_CH  one-cycle pulse; clk_out bit just went 1->0.
busy  out  1  state != HALT.
cfg_err  out  1  one-cycle pulse: cfg_we rejected.
tick_count  out  CNT_W  ticks executed since reset or sync_all.

Behaviour:
- Reset state: state = HALT; every div = 1, phase = 0, cnt = 0; clk_out = 0, rise_en = 0, fall_en = 0, busy = 0, cfg_err = 0, tick_count = 0; remaining = 0. Reset mid-burst aborts the burst and discards all configuration.
- All outputs are registered.
- FSM:
  - HALT -> RUN when run_mode = 1.
  - Otherwise HALT -> STEP when step_go = 1 and step_count != 0; remaining <= step_count.
  - step_go with step_count = 0 is ignored.
  - RUN -> HALT when run_mode = 0.
  - STEP -> HALT on the tick where remaining = 1. run_mode is ignored during STEP.
  - step_go outside HALT is ignored.
- Tick: a tick occurs on every edge where the current state is RUN, or STEP with remaining > 0.
  - Exactly step_count ticks per burst.
  - tick_count increments per tick and wraps modulo 2**CNT_W.
- Per-channel tick, with d = max(cfg div, 1):
  - If cnt = d-1: cnt <= 0, clk_out bit toggles, and the matching rise_en/fall_en bit is set for one cycle.
  - Otherwise cnt <= cnt + 1.
  - Output period = 2*d ticks.
- Strobes are 0 in any cycle without a toggle, including all HALT cycles.
- Config write (cfg_we = 1):
  - Accepted only in HALT. Loads div and phase for cfg_ch, sets cnt <= min(phase, d-1) and clk_out bit <= 0.
  - In RUN or STEP the write is dropped and cfg_err pulses next cycle.
- sync_all = 1, any state:
  - Every channel: cnt <= min(phase, d-1), clk_out <= 0, strobes 0; tick_count <= 0.
  - Overrides the tick in that cycle. FSM state and remaining are unaffected, but remaining still decrements if in STEP.
- Priorities and simultaneity:
  - reset > sync_all > cfg_we > tick.
  - run_mode = 1 and step_go together in HALT: RUN wins.
  - cfg_we and step_go together in HALT: the config is applied and the first burst tick (next cycle) uses it.
- Arithmetic: counters compare using the effective d; phase >= d is clamped as above; no other saturation.

Test Plan:
- Reset held 2 cycles, then released with run_mode = 0: clk_out = 0000, busy = 0, tick_count = 0 for 5 cycles.
- Defaults with run_mode = 1 for 8 cycles: every channel toggles each tick. rise_en = 1111 on ticks 1, 3, 5, 7; fall_en = 1111 on ticks 2, 4, 6, 8; tick_count = 8.
- In HALT, program ch2 div = 3 phase = 1 and ch3 div = 0, then run 12 ticks:
  - ch3 behaves as div 1.
  - ch2 first toggles (rise) on tick 2, then every 3 ticks: ticks 5, 8, 11.
- step_go with step_count = 5: busy is high for exactly 5 cycles, tick_count = 5, then HALT; a second step_go during busy is ignored.
- cfg_we while in RUN: cfg_err pulses once and the ch0 period is unchanged.
- sync_all mid-run with ch1 div = 2 phase = 1: clk_out = 0 and tick_count = 0 in the next cycle; ch1 then rises on the first tick after sync.
